// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: data widths, PC step, fetch entry layout and a
// pointer-width helper.
package cpu_pkg;
   localparam int                 INSTR_W   = 32;
   localparam int                 ADDR_W    = 32;
   localparam int                 PC_STEP   = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs; flush empties it in one cycle and
// the head output holds the last shown entry while the queue is empty.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  fetch_entry_t           push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [clog2(DEPTH):0]  count_o,
   output logic                   valid_o,
   output fetch_entry_t           head_o
);
   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   fetch_entry_t     hold_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && (count_reg != '0);
   assign do_push = push_i && (count_reg != CNT_W'(DEPTH));

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem[wr_ptr_reg] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         hold_reg   <= '{pc: RESET_PC, instr: NOP_INSTR};
      end else begin
         // Track the visible head so an empty queue keeps presenting it.
         if (count_reg != '0) begin
            hold_reg <= mem[rd_ptr_reg];
         end
         if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end

   assign count_o = count_reg;
   assign valid_o = (count_reg != '0);
   assign head_o  = valid_o ? mem[rd_ptr_reg] : hold_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited in-order memory
// requests, redirect flush with stale-response discard. Optional counters: FETCH_PERF_EN.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_ready_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [ADDR_W-1:0]  pc_add4_o,
   input  logic               instr_ready_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_cnt_o,
   output logic [31:0]        flush_cnt_o,
   output logic [31:0]        stall_cnt_o
`endif
);
   localparam int                CNT_W    = clog2(DEPTH) + 1;
   localparam int                SUM_W    = CNT_W + 1;
   localparam logic [ADDR_W-1:0] ALIGN_M  = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ALIGN_M;

   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [ADDR_W-1:0] rsp_pc_reg;
   logic [CNT_W-1:0]  outstanding_reg;
   logic [CNT_W-1:0]  discard_reg;
   logic [CNT_W-1:0]  outstanding_next;
   logic [CNT_W-1:0]  q_count;
   logic [SUM_W-1:0]  in_use;
   logic              q_valid;
   logic              req_fire;
   logic              rsp_fire;
   logic              rsp_keep;
   logic              pop;
   fetch_entry_t      q_head;

   // Every queue slot is pre-reserved by an outstanding request, so a push never overflows.
   assign in_use     = SUM_W'(q_count) + SUM_W'(outstanding_reg);
   assign imem_req_o = !rst_i && !redirect_i && (in_use < SUM_W'(DEPTH));
   assign imem_addr_o = fetch_pc_reg;

   assign req_fire = imem_req_o && imem_ready_i;
   assign rsp_fire = imem_rvalid_i && (outstanding_reg != '0);
   assign rsp_keep = rsp_fire && (discard_reg == '0) && !redirect_i;
   assign pop      = q_valid && instr_ready_i && !redirect_i;
   assign outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_reg    <= START_PC;
         rsp_pc_reg      <= START_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else if (redirect_i) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_reg    <= redirect_pc_i & ALIGN_M;
         rsp_pc_reg      <= redirect_pc_i & ALIGN_M;
         outstanding_reg <= outstanding_next;
         discard_reg     <= outstanding_next;
      end else begin
         if (req_fire) fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_STEP);
         if (rsp_keep) rsp_pc_reg   <= rsp_pc_reg + ADDR_W'(PC_STEP);
         if (rsp_fire && (discard_reg != '0)) discard_reg <= discard_reg - 1'b1;
         outstanding_reg <= outstanding_next;
      end
   end

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (START_PC)
   ) u_queue (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (rsp_keep),
      .push_data_i ('{pc: rsp_pc_reg, instr: imem_rdata_i}),
      .pop_i       (pop),
      .flush_i     (redirect_i),
      .count_o     (q_count),
      .valid_o     (q_valid),
      .head_o      (q_head)
   );

   assign instr_valid_o = q_valid;
   assign instr_o       = q_head.instr;
   assign pc_o          = q_head.pc;
   assign pc_add4_o     = q_head.pc + ADDR_W'(PC_STEP);

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] flush_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (pop)            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (redirect_i)     flush_cnt_reg <= flush_cnt_reg + 32'd1;
         if (!instr_valid_o) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt_reg;
   assign flush_cnt_o = flush_cnt_reg;
   assign stall_cnt_o = stall_cnt_reg;
`endif

   a_rsp_needs_request: assert property (@(posedge clk_i) disable iff (rst_i)
      imem_rvalid_i |-> (outstanding_reg != '0));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_add4;
   logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] stall_cnt;
`endif

   int cmp_cnt = 0;
   int err_cnt = 0;
   int mem_lat = 1;
   int cyc = 0;

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (imem_ready),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .pc_o          (pc),
      .pc_add4_o     (pc_add4),
      .instr_ready_i (instr_ready)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt_o   (fetch_cnt),
      .flush_cnt_o   (flush_cnt),
      .stall_cnt_o   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Memory model: word at address A is A + 32'h1000_0000, returned mem_lat cycles after accept.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t pend[$];

   always begin
      @(negedge clk);
      if (rst) begin
         pend.delete();
      end else begin
         if (imem_rvalid) void'(pend.pop_front());
         if (imem_req && imem_ready) pend.push_back('{imem_addr, cyc + mem_lat});
      end
      @(posedge clk);
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend[0].addr + 32'h1000_0000;
      end else begin
         imem_rvalid = 1'b0;
      end
   end

`ifdef FETCH_PERF_EN
   int stall_exp = 0;
   bit stall_rst = 1'b1;
   bit stall_inc = 1'b0;
   always @(negedge clk) begin
      stall_rst = rst;
      stall_inc = !rst && !instr_valid;
   end
   always @(posedge clk) begin
      if (stall_rst) stall_exp = 0;
      else if (stall_inc) stall_exp++;
   end
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      redirect = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_ctl: got req=%0b valid=%0b required 0 0", imem_req, instr_valid);
      end
      cmp_cnt++;
      if (instr !== 32'h0 || pc !== 32'h0 || pc_add4 !== 32'h4) begin
         err_cnt++;
         $display("FAIL reset_data: got instr=%h pc=%h pc4=%h required 0 0 4", instr, pc, pc_add4);
      end
      $display("test_reset: req=%0b valid=%0b pc=%h", imem_req, instr_valid, pc);
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      mem_lat = 1;
      instr_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         cmp_cnt++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
            err_cnt++;
            $display("FAIL seq_addr[%0d]: got req=%0b addr=%h required 1 %h", i, imem_req, imem_addr, 32'(4 * i));
         end
         cmp_cnt++;
         if (i < 2) begin
            if (instr_valid !== 1'b0) begin
               err_cnt++;
               $display("FAIL seq_early_valid[%0d]: got %0b required 0", i, instr_valid);
            end
         end else begin
            exp_pc = 32'(4 * (i - 2));
            if (instr_valid !== 1'b1 || pc !== exp_pc || pc_add4 !== exp_pc + 32'd4 ||
                instr !== exp_pc + 32'h1000_0000) begin
               err_cnt++;
               $display("FAIL seq_head[%0d]: got v=%0b pc=%h pc4=%h instr=%h required pc=%h", i,
                        instr_valid, pc, pc_add4, instr, exp_pc);
            end else begin
               $display("test_sequential: pop pc=%h instr=%h", pc, instr);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int reqs;
      reqs = 0;
      mem_lat = 1;
      instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         if (imem_req === 1'b1 && imem_ready === 1'b1) reqs++;
      end
      cmp_cnt++;
      if (reqs !== 4 || imem_req !== 1'b0) begin
         err_cnt++;
         $display("FAIL bp_credit: got reqs=%0d req=%0b required 4 0", reqs, imem_req);
      end
      tick();
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         @(negedge clk);
         cmp_cnt++;
         if (instr_valid !== 1'b1 || pc !== 32'(4 * k) || instr !== 32'(4 * k) + 32'h1000_0000) begin
            err_cnt++;
            $display("FAIL bp_pop[%0d]: got v=%0b pc=%h instr=%h required pc=%h", k, instr_valid, pc, instr, 32'(4 * k));
         end else begin
            $display("test_backpressure: pop pc=%h", pc);
         end
         if (k == 1) begin
            cmp_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
               err_cnt++;
               $display("FAIL bp_resume: got req=%0b addr=%h required 1 00000010", imem_req, imem_addr);
            end
         end
      end
   endtask

   task automatic test_redirect_stale();
      bit ok;
      mem_lat = 3;
      instr_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b0) begin
         err_cnt++;
         $display("FAIL redir_noreq: got req=%0b required 0", imem_req);
      end
      tick();
      redirect = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         err_cnt++;
         $display("FAIL redir_addr: got req=%0b addr=%h required 1 00000100", imem_req, imem_addr);
      end
      wait_valid(20, ok);
      cmp_cnt++;
      if (!ok || pc !== 32'h100 || pc_add4 !== 32'h104 || instr !== 32'h1000_0100) begin
         err_cnt++;
         $display("FAIL redir_head: got ok=%0b pc=%h pc4=%h instr=%h required pc=00000100 pc4=00000104", ok, pc, pc_add4, instr);
      end
      $display("test_redirect_stale: first pc=%h", pc);
      tick();
   endtask

   task automatic test_redirect_collide();
      bit ok;
      mem_lat = 1;
      instr_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h203;
      @(negedge clk);
      cmp_cnt++;
      if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0) begin
         err_cnt++;
         $display("FAIL coll_pre: got v=%0b pc=%h req=%0b required 1 0 0", instr_valid, pc, imem_req);
      end
      tick();
      redirect = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if (instr_valid !== 1'b0 || pc !== 32'h0) begin
         err_cnt++;
         $display("FAIL coll_flush: got v=%0b pc=%h required 0 00000000", instr_valid, pc);
      end
      cmp_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         err_cnt++;
         $display("FAIL coll_addr: got req=%0b addr=%h required 1 00000200", imem_req, imem_addr);
      end
      wait_valid(10, ok);
      cmp_cnt++;
      if (!ok || pc !== 32'h200 || instr !== 32'h1000_0200) begin
         err_cnt++;
         $display("FAIL coll_head: got ok=%0b pc=%h instr=%h required 00000200 10000200", ok, pc, instr);
      end
      $display("test_redirect_collide: first pc=%h", pc);
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      mem_lat = 3;
      instr_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      wait_valid(20, ok);
      cmp_cnt++;
      if (!ok || pc !== 32'h80 || instr !== 32'h1000_0080) begin
         err_cnt++;
         $display("FAIL b2b_head: got ok=%0b pc=%h instr=%h required 00000080 10000080", ok, pc, instr);
      end
      $display("test_back_to_back: first pc=%h", pc);
      tick();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a;
      mem_lat = 1;
      instr_ready = 1'b1;
      do_reset();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      exp_a = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
         tick();
         redirect = 1'b0;
         @(negedge clk);
         cmp_cnt++;
         if (imem_req !== 1'b1 || imem_addr !== exp_a) begin
            err_cnt++;
            $display("FAIL wrap_addr[%0d]: got req=%0b addr=%h required 1 %h", i, imem_req, imem_addr, exp_a);
         end
         exp_a = exp_a + 32'd4;
      end
      cmp_cnt++;
      if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFF8 || instr !== 32'h0FFF_FFF8) begin
         err_cnt++;
         $display("FAIL wrap_head0: got v=%0b pc=%h instr=%h required fffffff8 0ffffff8", instr_valid, pc, instr);
      end
      tick();
      @(negedge clk);
      cmp_cnt++;
      if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || pc_add4 !== 32'h0) begin
         err_cnt++;
         $display("FAIL wrap_head1: got v=%0b pc=%h pc4=%h required fffffffc 00000000", instr_valid, pc, pc_add4);
      end
      tick();
      @(negedge clk);
      cmp_cnt++;
      if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h1000_0000) begin
         err_cnt++;
         $display("FAIL wrap_head2: got v=%0b pc=%h instr=%h required 00000000 10000000", instr_valid, pc, instr);
      end
      $display("test_wrap: pc after wrap=%h", pc);
   endtask

   task automatic test_reset_midop();
      bit ok;
      mem_lat = 3;
      instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      @(negedge clk);
      cmp_cnt++;
      if (instr_valid !== 1'b1 || pc !== 32'h0) begin
         err_cnt++;
         $display("FAIL midrst_pre: got v=%0b pc=%h required 1 00000000", instr_valid, pc);
      end
      tick();
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || pc_add4 !== 32'h4) begin
         err_cnt++;
         $display("FAIL midrst_out: got req=%0b v=%0b instr=%h pc=%h pc4=%h required 0 0 0 0 4",
                  imem_req, instr_valid, instr, pc, pc_add4);
      end
      tick();
      rst = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      cmp_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         err_cnt++;
         $display("FAIL midrst_restart: got req=%0b addr=%h required 1 00000000", imem_req, imem_addr);
      end
      wait_valid(10, ok);
      cmp_cnt++;
      if (!ok || pc !== 32'h0 || instr !== 32'h1000_0000) begin
         err_cnt++;
         $display("FAIL midrst_head: got ok=%0b pc=%h instr=%h required 00000000 10000000", ok, pc, instr);
      end
      $display("test_reset_midop: restart pc=%h", pc);
      tick();
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      int pops;
      pops = 0;
      mem_lat = 1;
      instr_ready = 1'b1;
      do_reset();
      @(negedge clk);
      cmp_cnt++;
      if (fetch_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         err_cnt++;
         $display("FAIL perf_reset: got fetch=%0d flush=%0d required 0 0", fetch_cnt, flush_cnt);
      end
      for (int i = 0; i < 30 && pops < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (instr_valid === 1'b1) pops++;
         if (pops == 5) begin
            tick();
            instr_ready = 1'b0;
         end else begin
            tick();
         end
      end
      redirect = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      tick();
      @(negedge clk);
      cmp_cnt++;
      if (fetch_cnt !== 32'd5 || flush_cnt !== 32'd2) begin
         err_cnt++;
         $display("FAIL perf_cnt: got fetch=%0d flush=%0d required 5 2", fetch_cnt, flush_cnt);
      end
      cmp_cnt++;
      if (stall_cnt !== 32'(stall_exp)) begin
         err_cnt++;
         $display("FAIL perf_stall: got %0d required %0d", stall_cnt, stall_exp);
      end
      $display("test_perf: fetch=%0d flush=%0d stall=%0d", fetch_cnt, flush_cnt, stall_cnt);
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_stale();
      test_redirect_collide();
      test_back_to_back();
      test_wrap();
      test_reset_midop();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
